// File: rtl/imul_req_arbiter_if.sv
// rtl/imul_req_arbiter_if.sv - core/multiplier request and response bundle for imul_req_arbiter
// slave = arbiter side, master = environment (cores plus multiplier).
interface imul_req_arbiter_if #(
  parameter int NPORTS = 4
);
  logic [NPORTS-1:0]    core_req_val;
  logic [NPORTS-1:0]    core_req_rdy;
  logic [NPORTS*64-1:0] core_req_msg;
  logic [NPORTS-1:0]    core_resp_val;
  logic [NPORTS-1:0]    core_resp_rdy;
  logic [31:0]          core_resp_msg;
  logic                 mul_req_val;
  logic                 mul_req_rdy;
  logic [63:0]          mul_req_msg;
  logic                 mul_resp_val;
  logic                 mul_resp_rdy;
  logic [31:0]          mul_resp_msg;

  modport slave (
    input  core_req_val, core_req_msg, core_resp_rdy,
    input  mul_req_rdy, mul_resp_val, mul_resp_msg,
    output core_req_rdy, core_resp_val, core_resp_msg,
    output mul_req_val, mul_req_msg, mul_resp_rdy
  );

  modport master (
    output core_req_val, core_req_msg, core_resp_rdy,
    output mul_req_rdy, mul_resp_val, mul_resp_msg,
    input  core_req_rdy, core_resp_val, core_resp_msg,
    input  mul_req_val, mul_req_msg, mul_resp_rdy
  );
endinterface

// File: rtl/imul_req_arbiter.sv
// rtl/imul_req_arbiter.sv - shares one iterative multiplier among NPORTS cores, one transaction in flight
// Round-robin by default; define IMUL_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module imul_req_arbiter #(
  parameter int NPORTS = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  imul_req_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [PTR_W:0]   LAST_W = (PTR_W+1)'(NPORTS-1);
  localparam logic [PTR_W:0]   NP_W   = (PTR_W+1)'(NPORTS);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(NPORTS-1);

  state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_owner, w_owner_nxt;
  logic [PTR_W-1:0] r_prio, w_prio_nxt;
  logic [PTR_W-1:0] w_scan_base;
  logic [PTR_W-1:0] w_grant;
  logic             w_grant_val;
  logic [63:0]      w_grant_msg;

`ifdef IMUL_ARB_FIXED_PRIO_EN
  assign w_scan_base = '0;
`else
  assign w_scan_base = r_prio;
`endif

  // Scan wraps at NPORTS, not 2**PTR_W, so unused encodings are never granted.
  always_comb begin : grant_scan
    logic [PTR_W:0] w_idx;
    w_grant     = '0;
    w_grant_val = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NPORTS; k++) begin
      w_idx = {1'b0, w_scan_base} + (PTR_W+1)'(k);
      if (w_idx > LAST_W) w_idx = w_idx - NP_W;
      if (!w_grant_val && bus.core_req_val[w_idx[PTR_W-1:0]]) begin
        w_grant     = w_idx[PTR_W-1:0];
        w_grant_val = 1'b1;
      end
    end
  end

  always_comb begin : grant_mux
    w_grant_msg = bus.core_req_msg[63:0];
    for (int i = 1; i < NPORTS; i++) begin
      if (w_grant == PTR_W'(i)) w_grant_msg = bus.core_req_msg[64*i +: 64];
    end
  end

  always_comb begin : fsm_comb
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_prio_nxt        = r_prio;
    bus.mul_req_val   = 1'b0;
    bus.mul_req_msg   = w_grant_msg;
    bus.core_req_rdy  = '0;
    bus.core_resp_val = '0;
    bus.mul_resp_rdy  = 1'b0;
    bus.core_resp_msg = bus.mul_resp_msg;
    case (r_state)
      IDLE: begin
        bus.mul_req_val           = w_grant_val;
        bus.core_req_rdy[w_grant] = bus.mul_req_rdy & w_grant_val;
        if (w_grant_val && bus.mul_req_rdy) begin
          w_owner_nxt = w_grant;
          w_state_nxt = WAIT;
`ifndef IMUL_ARB_FIXED_PRIO_EN
          w_prio_nxt  = (w_grant == LAST_P) ? '0 : w_grant + PTR_W'(1);
`endif
        end
      end
      WAIT: begin
        bus.core_resp_val[r_owner] = bus.mul_resp_val;
        bus.mul_resp_rdy           = bus.core_resp_rdy[r_owner];
        if (bus.mul_resp_val && bus.core_resp_rdy[r_owner]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_prio  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end
endmodule

// File: tb/tb_imul_req_arbiter.sv
// tb/tb_imul_req_arbiter.sv - randomized scoreboard bench for imul_req_arbiter
// Reference grant model follows IMUL_ARB_FIXED_PRIO_EN when defined.
module tb_imul_req_arbiter;
  localparam int N  = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imul_req_arbiter_if #(.NPORTS(N)) bus ();
  imul_req_arbiter #(.NPORTS(N), .PTR_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [N-1:0] req_val  = '0;
  logic [N-1:0] resp_rdy = '0;
  logic [63:0]  req_msg [N];
  logic         m_req_rdy  = 1'b0;
  logic         m_resp_val = 1'b0;
  logic [31:0]  m_resp_msg = '0;

  assign bus.core_req_val  = req_val;
  assign bus.core_req_msg  = {req_msg[3], req_msg[2], req_msg[1], req_msg[0]};
  assign bus.core_resp_rdy = resp_rdy;
  assign bus.mul_req_rdy   = m_req_rdy;
  assign bus.mul_resp_val  = m_resp_val;
  assign bus.mul_resp_msg  = m_resp_msg;

  typedef struct { int port; logic [31:0] prod; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int m_prio = 0;
  bit m_busy = 0;
  bit mul_busy = 0;
  int mul_lat = 0;
  logic [31:0] mul_prod = '0;

  logic [N-1:0] port_mask = '0;
  int req_pct = 0, rdy_pct = 100, resp_pct = 100;
  bit spurious_en = 0, fixed_en = 0;
  logic [63:0] fixed_msg [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    int base;
`ifdef IMUL_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_prio;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    bit rq_fire, rs_fire;
    @(negedge clk);
    g = model_grant(req_val);
    rq_fire = 0;
    if (!m_busy) begin
      check("mul_req_val", {63'd0, bus.mul_req_val}, {63'd0, g >= 0});
      if (g >= 0) begin
        check("mul_req_msg", bus.mul_req_msg, req_msg[g]);
        check("core_req_rdy", {60'd0, bus.core_req_rdy}, m_req_rdy ? (64'd1 << g) : 64'd0);
        rq_fire = m_req_rdy;
      end else begin
        check("core_req_rdy_none", {60'd0, bus.core_req_rdy}, 64'd0);
      end
    end else begin
      check("core_req_rdy_wait", {60'd0, bus.core_req_rdy}, 64'd0);
      check("mul_req_val_wait", {63'd0, bus.mul_req_val}, 64'd0);
    end
    rs_fire = m_busy && m_resp_val && bus.mul_resp_rdy;
    @(posedge clk);
    #1;
    if (rs_fire) begin
      m_busy = 0;
      mul_busy = 0;
    end
    if (rq_fire) begin
      exp_q.push_back('{g, req_msg[g][31:0] * req_msg[g][63:32]});
      req_val[g] = 1'b0;
`ifndef IMUL_ARB_FIXED_PRIO_EN
      m_prio = (g + 1) % N;
`endif
      m_busy = 1;
      mul_busy = 1;
      mul_prod = req_msg[g][31:0] * req_msg[g][63:32];
      mul_lat = $urandom_range(0, 3);
    end
    if (mul_busy) begin
      m_req_rdy = 1'b0;
      if (mul_lat == 0) begin
        m_resp_val = 1'b1;
        m_resp_msg = mul_prod;
      end else begin
        mul_lat--;
        m_resp_val = 1'b0;
        m_resp_msg = $urandom;
      end
    end else begin
      m_req_rdy  = ($urandom_range(0, 99) < rdy_pct);
      m_resp_val = spurious_en && ($urandom_range(0, 3) == 0);
      m_resp_msg = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      if (!req_val[i] && port_mask[i] && ($urandom_range(0, 99) < req_pct)) begin
        req_val[i] = 1'b1;
        req_msg[i] = fixed_en ? fixed_msg[i] : {$urandom, $urandom};
      end
      resp_rdy[i] = ($urandom_range(0, 99) < resp_pct);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_val = '0;
    resp_rdy = '0;
    m_resp_val = 1'b0;
    m_req_rdy = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_prio = 0;
    m_busy = 0;
    mul_busy = 0;
    @(negedge clk);
    check("rst_core_req_rdy", {60'd0, bus.core_req_rdy}, 64'd0);
    check("rst_core_resp_val", {60'd0, bus.core_resp_val}, 64'd0);
    check("rst_mul_req_val", {63'd0, bus.mul_req_val}, 64'd0);
    check("rst_mul_resp_rdy", {63'd0, bus.mul_resp_rdy}, 64'd0);
    check("rst_mul_req_msg", bus.mul_req_msg, req_msg[0]);
    check("rst_core_resp_msg", {32'd0, bus.core_resp_msg}, {32'd0, m_resp_msg});
  endtask

  task automatic drain();
    int n;
    port_mask = '0;
    resp_pct = 100;
    rdy_pct = 100;
    n = 0;
    while ((req_val != '0 || m_busy) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (req_val != '0 || m_busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  initial begin : monitor
    int fired;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        fired = -1;
        for (int i = 0; i < N; i++) begin
          if (bus.core_resp_val[i] && resp_rdy[i]) fired = i;
        end
        if (bus.core_resp_val != '0 || exp_q.size() != 0) begin
          check("resp_onehot", {63'd0, $countones(bus.core_resp_val) <= 1}, 64'd1);
        end
        if (exp_q.size() != 0) begin
          check("core_resp_val", {60'd0, bus.core_resp_val},
                m_resp_val ? (64'd1 << exp_q[0].port) : 64'd0);
          check("mul_resp_rdy", {63'd0, bus.mul_resp_rdy}, {63'd0, resp_rdy[exp_q[0].port]});
        end else if (m_resp_val) begin
          check("idle_resp_val", {60'd0, bus.core_resp_val}, 64'd0);
          check("idle_mul_resp_rdy", {63'd0, bus.mul_resp_rdy}, 64'd0);
        end
        if (fired >= 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=port%0d required=none", fired);
          end else begin
            e = exp_q.pop_front();
            check("resp_port", 64'(fired), 64'(e.port));
            check("resp_msg", {32'd0, bus.core_resp_msg}, {32'd0, e.prod});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < N; i++) begin
      req_msg[i]   = {$urandom, $urandom};
      fixed_msg[i] = 64'd0;
    end
    do_reset();

    // single requester on port 2: 3 * 7
    fixed_en = 1;
    fixed_msg[2] = {32'd7, 32'd3};
    port_mask = 4'b0100;
    req_pct = 100;
    for (int c = 0; c < 20; c++) step();
    drain();

    // all ports continuously valid: rotation 0,1,2,3,...
    for (int i = 0; i < N; i++) fixed_msg[i] = {32'd10, 32'(i + 1)};
    port_mask = 4'b1111;
    for (int c = 0; c < 60; c++) step();
    drain();

    // ports 0 and 2 continuously valid (fixed-priority build always picks 0)
    port_mask = 4'b0101;
    rdy_pct = 50;
    for (int c = 0; c < 60; c++) step();
    drain();

    // randomized traffic with back-pressure on both sides and spurious idle responses
    fixed_en = 0;
    port_mask = 4'b1111;
    req_pct = 40;
    rdy_pct = 60;
    resp_pct = 50;
    spurious_en = 1;
    for (int c = 0; c < 2000; c++) step();
    spurious_en = 0;
    drain();

    // reset while port 1 is in flight; response is dropped
    fixed_en = 1;
    fixed_msg[1] = {32'd2, 32'hFFFF_FFFF};
    port_mask = 4'b0010;
    req_pct = 100;
    resp_pct = 0;
    n = 0;
    while (!m_busy && n < 50) begin
      step();
      n++;
    end
    step();
    checks++;
    if (!m_busy) begin
      errors++;
      $display("FAIL reach_wait actual=idle required=wait");
    end
    do_reset();

    // after reset prio is 0, so port 1 beats port 3; port 3 yields 25
    fixed_msg[1] = {32'd7, 32'd6};
    fixed_msg[3] = {32'd5, 32'd5};
    port_mask = 4'b1010;
    resp_pct = 100;
    for (int c = 0; c < 4; c++) step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
